adder_bist_checker: RTL
=======================

// Module: adder_bist_checker
// PURPOSE
//  Synthesizable self-test driver and checker for the combinational N-bit adder
//  (ports A, B -> Sum, Carry). It walks every {A,B} vector, compares each
//  result with an internal golden sum, counts mismatches and records the first
//  failing vector. It sits beside the adder in the lab top level and replaces
//  simulator-only checking on hardware.
// PARAMETERS
//  WIDTH   2  operand width of the adder under test
//  SETTLE  2  cycles each vector is held before sampling; must be >= 1
//  ERR_W   5  width of the error counter; default holds 2^(2*WIDTH) = 16
// PORTS
//  clk              in   1          rising-edge clock
//  rst              in   1          synchronous, active-high reset
//  start            in   1          request a test run; sampled in IDLE or DONE
//  dut_a            out  WIDTH      operand A driven to the adder
//  dut_b            out  WIDTH      operand B driven to the adder
//  dut_sum          in   WIDTH      adder Sum
//  dut_carry        in   1          adder Carry
//  busy             out  1          a run is in progress
//  done             out  1          run complete; results valid
//  pass             out  1          done and err_count == 0
//  err_count        out  ERR_W      number of mismatching vectors, saturating
//  first_fail_valid out  1          at least one mismatch captured
//  first_fail_vec   out  2*WIDTH    {A,B} of the first mismatch
// BEHAVIOUR
//  - Reset: on rst high at a clk edge, go to IDLE. All outputs become 0.
//    This also applies mid-run. rst has priority over start.
//  - States: IDLE, SETTLE, CHECK, DONE. All outputs are registered.
//  - IDLE --start--> SETTLE, with V = 0, settle count = 0, err_count = 0,
//    first_fail_valid = 0, first_fail_vec = 0.
//  - {dut_a, dut_b} = V (A is the upper WIDTH bits) for the whole run.
//  - SETTLE holds for exactly SETTLE cycles, then goes to CHECK.
//  - CHECK lasts one cycle. At the edge leaving CHECK, compare
//    {dut_carry, dut_sum} with exp = dut_a + dut_b (WIDTH+1 bits, zero-extended).
//    - On mismatch: err_count += 1, saturating at 2^ERR_W-1.
//    - If first_fail_valid == 0 on mismatch: set it and latch first_fail_vec = V.
//    - If V == all-ones, go to DONE. Otherwise V += 1 and go back to SETTLE.
//  - Latency: done rises 2^(2*WIDTH)*(SETTLE+1) edges after the edge that
//    sampled start. This is 48 for the defaults.
//  - busy = 1 in SETTLE and CHECK. done = 1 only in DONE.
//    pass = done & (err_count == 0).
//  - DONE holds results and dut_a/dut_b. start in DONE restarts exactly as it
//    does from IDLE.
//  - start while busy is ignored. A start level held high across DONE
//    restarts once per entry to DONE.
//  - V never wraps inside a run. The last vector exits to DONE.
// STRUCTURE
//  - Shared package/header: state encodings (IDLE=0, SETTLE=1, CHECK=2,
//    DONE=3) and the N_VEC = 1 << (2*WIDTH) localparam.
//  - One sub-module: adder_bist_ref, a combinational golden model
//    (a, b -> {carry, sum}). It is kept separate so it can be reused by other
//    lab checkers.
//  - FSM, vector counter, settle counter, error counter and capture registers
//    stay in this module.
// TESTING
//  1. Good adder, defaults: pulse start -> busy for 48 cycles; then done = 1,
//     pass = 1, err_count = 0, first_fail_valid = 0.
//  2. Carry stuck at 0 -> err_count = 6, pass = 0, first_fail_vec = 4'b0111.
//  3. Sum[0] inverted -> err_count = 16, first_fail_vec = 4'b0000,
//     first_fail_valid = 1.
//  4. ERR_W = 3 with the sum[0]-inverted DUT -> err_count saturates at 7;
//     done still arrives at cycle 48.
//  5. start pulsed at cycles 10 and 30 of a run -> no effect, done still at 48.
//     Then start in DONE -> counters cleared, a second run gives identical
//     results.
//  6. rst high at cycle 20 of a run -> next edge: IDLE, dut_a = dut_b = 0,
//     busy = done = pass = 0, err_count = 0. A later start runs a full 48-cycle
//     pass.

Source files
------------

// File: rtl/adder_bist_checker_pkg.sv
// rtl/adder_bist_checker_pkg.sv - shared types and constants for the adder BIST checker
//
// Purpose : state encoding of the BIST FSM and vector-space helpers.
// Ports   : none (package).
package adder_bist_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } bist_state_t;

  localparam int DEFAULT_WIDTH = 2;
  localparam int N_VEC         = 1 << (2 * DEFAULT_WIDTH);

  // Number of {A,B} vectors for an adder of the given operand width.
  function automatic int n_vec(input int width);
    return 1 << (2 * width);
  endfunction

endpackage

// File: rtl/adder_bist_ref.sv
// rtl/adder_bist_ref.sv - combinational golden model of an N-bit adder
//
// Purpose : produces the expected {carry, sum} for operands a and b.
// Ports   : a       in  WIDTH    operand A
//           b       in  WIDTH    operand B
//           sum_ext out WIDTH+1  {carry, sum}, zero-extended addition
module adder_bist_ref
  import adder_bist_checker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum_ext
);

  assign sum_ext = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_bist_checker.sv
// rtl/adder_bist_checker.sv - self-test driver and checker for a combinational adder
//
// Purpose : walks every {A,B} vector, holds each for SETTLE cycles, compares
//           the adder output against a golden sum, counts mismatches
//           (saturating) and captures the first failing vector.
// Ports   : clk, rst (sync, active high), start
//           dut_a, dut_b          operands driven to the adder under test
//           dut_sum, dut_carry    adder outputs
//           busy, done, pass      run status (registered)
//           err_count             saturating mismatch count
//           first_fail_valid/vec  capture of the first mismatching {A,B}
module adder_bist_checker
  import adder_bist_checker_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  input  logic [WIDTH-1:0]     dut_sum,
  input  logic                 dut_carry,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic                 first_fail_valid,
  output logic [2*WIDTH-1:0]   first_fail_vec
);

  localparam int VW = 2 * WIDTH;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [VW-1:0] LAST_VEC    = VW'(n_vec(WIDTH) - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  bist_state_t       state_q, state_d;
  logic [VW-1:0]     vec_q, vec_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              ffv_q, ffv_d;
  logic [VW-1:0]     ffvec_q, ffvec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [WIDTH:0]    exp_sum;
  logic              mismatch;

  adder_bist_ref #(.WIDTH(WIDTH)) u_ref (
    .a       (vec_q[VW-1:WIDTH]),
    .b       (vec_q[WIDTH-1:0]),
    .sum_ext (exp_sum)
  );

  assign mismatch = ({dut_carry, dut_sum} != exp_sum);

  // Status outputs are computed from the next state so that they are
  // registered alongside it and never lag the FSM by a cycle.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    pass_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          vec_d    = '0;
          settle_d = '0;
          err_d    = '0;
          ffv_d    = 1'b0;
          ffvec_d  = '0;
          busy_d   = 1'b1;
        end else if (state_q == ST_DONE) begin
          done_d = 1'b1;
          pass_d = (err_q == '0);
        end
      end

      ST_SETTLE: begin
        busy_d = 1'b1;
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
        end
        // The last vector leaves for DONE instead of wrapping back to 0.
        if (vec_q == LAST_VEC) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d  = ST_SETTLE;
          vec_d    = vec_q + 1'b1;
          settle_d = '0;
          busy_d   = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign dut_a            = vec_q[VW-1:WIDTH];
  assign dut_b            = vec_q[WIDTH-1:0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule
